// File: rtl/decode_branch_ctrl_pkg.sv
// Shared opcode/func encodings, ALU/dsize/fpoint codes and the decoded-control payload
// for the DLX decode-stage controller (FP decode gated by FPU_DECODE_EN).
package decode_branch_ctrl_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned RW   = 5;
  localparam int unsigned OPW  = 6;
  localparam int unsigned ALUW = 4;

  // Primary opcodes
  localparam logic [OPW-1:0] OP_RTYPE  = 6'h00;
  localparam logic [OPW-1:0] OP_FRTYPE = 6'h01;
  localparam logic [OPW-1:0] OP_J      = 6'h02;
  localparam logic [OPW-1:0] OP_JAL    = 6'h03;
  localparam logic [OPW-1:0] OP_BEQZ   = 6'h04;
  localparam logic [OPW-1:0] OP_BNEZ   = 6'h05;
  localparam logic [OPW-1:0] OP_BFPT   = 6'h06;
  localparam logic [OPW-1:0] OP_BFPF   = 6'h07;
  localparam logic [OPW-1:0] OP_ADDI   = 6'h08;
  localparam logic [OPW-1:0] OP_ADDUI  = 6'h09;
  localparam logic [OPW-1:0] OP_SUBI   = 6'h0A;
  localparam logic [OPW-1:0] OP_SUBUI  = 6'h0B;
  localparam logic [OPW-1:0] OP_ANDI   = 6'h0C;
  localparam logic [OPW-1:0] OP_ORI    = 6'h0D;
  localparam logic [OPW-1:0] OP_XORI   = 6'h0E;
  localparam logic [OPW-1:0] OP_LHI    = 6'h0F;
  localparam logic [OPW-1:0] OP_RFE    = 6'h10;
  localparam logic [OPW-1:0] OP_TRAP   = 6'h11;
  localparam logic [OPW-1:0] OP_JR     = 6'h12;
  localparam logic [OPW-1:0] OP_JALR   = 6'h13;
  localparam logic [OPW-1:0] OP_SLLI   = 6'h14;
  localparam logic [OPW-1:0] OP_NOP    = 6'h15;
  localparam logic [OPW-1:0] OP_SRLI   = 6'h16;
  localparam logic [OPW-1:0] OP_SRAI   = 6'h17;
  localparam logic [OPW-1:0] OP_SEQI   = 6'h18;
  localparam logic [OPW-1:0] OP_SGEI   = 6'h1D;
  localparam logic [OPW-1:0] OP_LB     = 6'h20;
  localparam logic [OPW-1:0] OP_LH     = 6'h21;
  localparam logic [OPW-1:0] OP_LW     = 6'h23;
  localparam logic [OPW-1:0] OP_LBU    = 6'h24;
  localparam logic [OPW-1:0] OP_LHU    = 6'h25;
  localparam logic [OPW-1:0] OP_LF     = 6'h26;
  localparam logic [OPW-1:0] OP_LD     = 6'h27;
  localparam logic [OPW-1:0] OP_SB     = 6'h28;
  localparam logic [OPW-1:0] OP_SH     = 6'h29;
  localparam logic [OPW-1:0] OP_SW     = 6'h2B;
  localparam logic [OPW-1:0] OP_SF     = 6'h2E;
  localparam logic [OPW-1:0] OP_SD     = 6'h2F;

  // R-type function codes
  localparam logic [5:0] F_SLL  = 6'h04;
  localparam logic [5:0] F_SRL  = 6'h06;
  localparam logic [5:0] F_SRA  = 6'h07;
  localparam logic [5:0] F_ADD  = 6'h20;
  localparam logic [5:0] F_ADDU = 6'h21;
  localparam logic [5:0] F_SUB  = 6'h22;
  localparam logic [5:0] F_SUBU = 6'h23;
  localparam logic [5:0] F_AND  = 6'h24;
  localparam logic [5:0] F_OR   = 6'h25;
  localparam logic [5:0] F_XOR  = 6'h26;
  localparam logic [5:0] F_SEQ  = 6'h28;
  localparam logic [5:0] F_SGE  = 6'h2D;

  // ALU operation codes; set-compares occupy 8..13 in SEQ,SNE,SLT,SGT,SLE,SGE order
  localparam logic [ALUW-1:0] ALU_ADD = 4'd0;
  localparam logic [ALUW-1:0] ALU_SUB = 4'd1;
  localparam logic [ALUW-1:0] ALU_AND = 4'd2;
  localparam logic [ALUW-1:0] ALU_OR  = 4'd3;
  localparam logic [ALUW-1:0] ALU_XOR = 4'd4;
  localparam logic [ALUW-1:0] ALU_SLL = 4'd5;
  localparam logic [ALUW-1:0] ALU_SRL = 4'd6;
  localparam logic [ALUW-1:0] ALU_SRA = 4'd7;
  localparam logic [ALUW-1:0] ALU_SEQ = 4'd8;
  localparam logic [ALUW-1:0] ALU_LHI = 4'd14;

  localparam logic [1:0] DSIZE_B = 2'b00;
  localparam logic [1:0] DSIZE_H = 2'b01;
  localparam logic [1:0] DSIZE_W = 2'b10;
  localparam logic [1:0] DSIZE_D = 2'b11;

  localparam logic [1:0] FP_INT    = 2'b00;
  localparam logic [1:0] FP_SINGLE = 2'b01;
  localparam logic [1:0] FP_DOUBLE = 2'b10;

  typedef struct packed {
    logic            valid;
    logic [ALUW-1:0] op;
  } alu_map_t;

  typedef struct packed {
    logic            regdst;
    logic            alusrc;
    logic            mem2reg;
    logic            regwrite;
    logic            memwrite;
    logic            loadext;
    logic            jump;
    logic            jal;
    logic            jar;
    logic            brnch;
    logic            br_nz;
    logic            imm_zext;
    logic [ALUW-1:0] aluctrl;
    logic [1:0]      dsize;
    logic [1:0]      fpoint;
  } ctrl_t;

  // R-type function field to ALU operation; valid=0 marks an unsupported func
  function automatic alu_map_t func_alu(input logic [5:0] f);
    alu_map_t m;
    m = '0;
    case (f) inside
      F_ADD, F_ADDU: m = '{valid: 1'b1, op: ALU_ADD};
      F_SUB, F_SUBU: m = '{valid: 1'b1, op: ALU_SUB};
      F_AND:         m = '{valid: 1'b1, op: ALU_AND};
      F_OR:          m = '{valid: 1'b1, op: ALU_OR};
      F_XOR:         m = '{valid: 1'b1, op: ALU_XOR};
      F_SLL:         m = '{valid: 1'b1, op: ALU_SLL};
      F_SRL:         m = '{valid: 1'b1, op: ALU_SRL};
      F_SRA:         m = '{valid: 1'b1, op: ALU_SRA};
      [F_SEQ:F_SGE]: m = '{valid: 1'b1, op: ALU_SEQ + ALUW'(f - F_SEQ)};
      default:       m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/decode_branch_ctrl_decode_ctrl_table.sv
// Combinational opcode/func to control-strobe decoder for the DLX decode stage.
// FP opcodes decode only when FPU_DECODE_EN is defined; otherwise they behave as NOP.
module decode_ctrl_table
  import decode_branch_ctrl_pkg::*;
(
  input  logic [OPW-1:0] opcode,
  input  logic [5:0]     func,
  output ctrl_t          ctrl
);

  alu_map_t rmap;

  always_comb begin
    rmap = func_alu(func);
    ctrl = '0;
    case (opcode) inside
      OP_RTYPE: begin
        if (rmap.valid) begin
          ctrl.regdst   = 1'b1;
          ctrl.regwrite = 1'b1;
          ctrl.aluctrl  = rmap.op;
        end
      end
      OP_J: ctrl.jump = 1'b1;
      OP_JR: begin
        ctrl.jump = 1'b1;
        ctrl.jar  = 1'b1;
      end
      OP_JAL, OP_JALR: begin
        // Link writes the return address into R31
        ctrl.jump     = 1'b1;
        ctrl.jal      = 1'b1;
        ctrl.jar      = opcode[4];
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
      end
      OP_BEQZ, OP_BNEZ: begin
        ctrl.brnch = 1'b1;
        ctrl.br_nz = opcode[0];
      end
      OP_ADDI, OP_ADDUI, OP_SUBI, OP_SUBUI, OP_ANDI, OP_ORI, OP_XORI, OP_LHI,
      OP_SLLI, OP_SRLI, OP_SRAI, [OP_SEQI:OP_SGEI]: begin
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        case (opcode) inside
          OP_ADDI, OP_ADDUI: ctrl.aluctrl = ALU_ADD;
          OP_SUBI, OP_SUBUI: ctrl.aluctrl = ALU_SUB;
          OP_ANDI:           ctrl.aluctrl = ALU_AND;
          OP_ORI:            ctrl.aluctrl = ALU_OR;
          OP_XORI:           ctrl.aluctrl = ALU_XOR;
          OP_LHI:            ctrl.aluctrl = ALU_LHI;
          OP_SLLI:           ctrl.aluctrl = ALU_SLL;
          OP_SRLI:           ctrl.aluctrl = ALU_SRL;
          OP_SRAI:           ctrl.aluctrl = ALU_SRA;
          default:           ctrl.aluctrl = ALU_SEQ + ALUW'(opcode - OP_SEQI);
        endcase
        // Unsigned, logical, shift and LHI immediates are zero-extended
        ctrl.imm_zext = (opcode == OP_ADDUI) || (opcode == OP_SUBUI) ||
                        (opcode == OP_ANDI)  || (opcode == OP_ORI)   ||
                        (opcode == OP_XORI)  || (opcode == OP_LHI)   ||
                        (opcode == OP_SLLI)  || (opcode == OP_SRLI)  ||
                        (opcode == OP_SRAI);
      end
      OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
        ctrl.mem2reg  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctrl  = ALU_ADD;
        ctrl.loadext  = (opcode == OP_LB) || (opcode == OP_LH);
        case (opcode)
          OP_LB, OP_LBU: ctrl.dsize = DSIZE_B;
          OP_LH, OP_LHU: ctrl.dsize = DSIZE_H;
          default:       ctrl.dsize = DSIZE_W;
        endcase
      end
      OP_SB, OP_SH, OP_SW: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctrl  = ALU_ADD;
        case (opcode)
          OP_SB:   ctrl.dsize = DSIZE_B;
          OP_SH:   ctrl.dsize = DSIZE_H;
          default: ctrl.dsize = DSIZE_W;
        endcase
      end
`ifdef FPU_DECODE_EN
      OP_FRTYPE: begin
        ctrl.regdst   = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.fpoint   = func[0] ? FP_DOUBLE : FP_SINGLE;
      end
      OP_BFPT, OP_BFPF: begin
        // FP branches test the inverse polarity of BEQZ/BNEZ on opcode bit 0
        ctrl.brnch = 1'b1;
        ctrl.br_nz = ~opcode[0];
      end
      OP_LF, OP_LD: begin
        ctrl.mem2reg  = 1'b1;
        ctrl.regwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctrl  = ALU_ADD;
        ctrl.fpoint   = opcode[0] ? FP_DOUBLE : FP_SINGLE;
        ctrl.dsize    = opcode[0] ? DSIZE_D : DSIZE_W;
      end
      OP_SF, OP_SD: begin
        ctrl.memwrite = 1'b1;
        ctrl.alusrc   = 1'b1;
        ctrl.aluctrl  = ALU_ADD;
        ctrl.fpoint   = opcode[0] ? FP_DOUBLE : FP_SINGLE;
        ctrl.dsize    = opcode[0] ? DSIZE_D : DSIZE_W;
      end
`endif
      default: ctrl = '0;
    endcase
  end

endmodule

// File: rtl/decode_branch_ctrl.sv
// DLX decode-stage controller: IF/ID latch, control decode, ID-stage branch resolution.
// Defining FPU_DECODE_EN enables FP R-type, FP branch and FP load/store decode.
module decode_branch_ctrl
  import decode_branch_ctrl_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            stall,
  input  logic [XLEN-1:0] inst_in,
  input  logic [XLEN-1:0] delay_in,
  input  logic [XLEN-1:0] delay2_in,
  input  logic [XLEN-1:0] rs1_data,
  input  logic [XLEN-1:0] prior_alu,
  input  logic [XLEN-1:0] wb_data,
  input  logic [1:0]      fwd_sel_a,
  output logic [XLEN-1:0] instruction,
  output logic [XLEN-1:0] delay2_out,
  output logic [XLEN-1:0] imm32,
  output logic [XLEN-1:0] branch_target,
  output logic [XLEN-1:0] jump_target,
  output logic            branch,
  output logic            jump,
  output logic            jal,
  output logic            jar,
  output logic            regdst,
  output logic            alusrc,
  output logic            mem2reg,
  output logic            regwrite,
  output logic            memwrite,
  output logic            loadext,
  output logic [ALUW-1:0] aluctrl,
  output logic [1:0]      fpoint_out,
  output logic [1:0]      dsize,
  output logic [RW-1:0]   rs1,
  output logic [RW-1:0]   rs2,
  output logic [RW-1:0]   destreg
);

  logic [XLEN-1:0] delay_q;
  logic [XLEN-1:0] delay2_q;
  logic [XLEN-1:0] operand;
  logic [RW-1:0]   rd;
  logic            zero;
  ctrl_t           ctrl;

  // IF/ID latch; reset wins over stall
  always_ff @(posedge clk) begin
    if (rst) begin
      instruction <= '0;
      delay_q     <= '0;
      delay2_q    <= '0;
    end else if (!stall) begin
      instruction <= inst_in;
      delay_q     <= delay_in;
      delay2_q    <= delay2_in;
    end
  end

  decode_ctrl_table u_table (
    .opcode (instruction[31:26]),
    .func   (instruction[5:0]),
    .ctrl   (ctrl)
  );

  // Compare operand forwarding mux
  always_comb begin
    operand = '0;
    case (fwd_sel_a)
      2'd0:    operand = rs1_data;
      2'd1:    operand = prior_alu;
      2'd2:    operand = wb_data;
      default: operand = '0;
    endcase
  end

  assign zero   = (operand == '0);
  assign branch = ctrl.brnch & (ctrl.br_nz ? ~zero : zero);

  assign imm32 = ctrl.imm_zext ? {16'h0000, instruction[15:0]}
                               : {{16{instruction[15]}}, instruction[15:0]};

  // Target adders wrap modulo 2^32
  assign branch_target = delay_q + {imm32[XLEN-1:2], 2'b00};
  assign jump_target   = delay_q + {{6{instruction[25]}}, instruction[25:2], 2'b00};

  assign rs1     = instruction[25:21];
  assign rs2     = instruction[20:16];
  assign rd      = ctrl.jal ? RW'(31) : instruction[15:11];
  assign destreg = ctrl.regdst ? rd : rs2;

  assign delay2_out = delay2_q;
  assign jump       = ctrl.jump;
  assign jal        = ctrl.jal;
  assign jar        = ctrl.jar;
  assign regdst     = ctrl.regdst;
  assign alusrc     = ctrl.alusrc;
  assign mem2reg    = ctrl.mem2reg;
  assign regwrite   = ctrl.regwrite;
  assign memwrite   = ctrl.memwrite;
  assign loadext    = ctrl.loadext;
  assign aluctrl    = ctrl.aluctrl;
  assign fpoint_out = ctrl.fpoint;
  assign dsize      = ctrl.dsize;

endmodule

// File: tb/tb_decode_branch_ctrl.sv
// Directed self-checking bench for decode_branch_ctrl using an expectation queue.
module tb_decode_branch_ctrl;

  logic        clk = 1'b0;
  logic        rst, stall;
  logic [31:0] inst_in, delay_in, delay2_in, rs1_data, prior_alu, wb_data;
  logic [1:0]  fwd_sel_a;
  logic [31:0] instruction, delay2_out, imm32, branch_target, jump_target;
  logic        branch, jump, jal, jar, regdst, alusrc, mem2reg, regwrite, memwrite, loadext;
  logic [3:0]  aluctrl;
  logic [1:0]  fpoint_out, dsize;
  logic [4:0]  rs1, rs2, destreg;

  decode_branch_ctrl dut (
    .clk(clk), .rst(rst), .stall(stall), .inst_in(inst_in), .delay_in(delay_in),
    .delay2_in(delay2_in), .rs1_data(rs1_data), .prior_alu(prior_alu), .wb_data(wb_data),
    .fwd_sel_a(fwd_sel_a), .instruction(instruction), .delay2_out(delay2_out),
    .imm32(imm32), .branch_target(branch_target), .jump_target(jump_target),
    .branch(branch), .jump(jump), .jal(jal), .jar(jar), .regdst(regdst), .alusrc(alusrc),
    .mem2reg(mem2reg), .regwrite(regwrite), .memwrite(memwrite), .loadext(loadext),
    .aluctrl(aluctrl), .fpoint_out(fpoint_out), .dsize(dsize), .rs1(rs1), .rs2(rs2),
    .destreg(destreg)
  );

  always #5 clk = ~clk;

  localparam int S_INST = 0, S_D2 = 1, S_IMM = 2, S_BT = 3, S_JT = 4, S_BR = 5,
                 S_JMP = 6, S_JAL = 7, S_JAR = 8, S_RDST = 9, S_ASRC = 10, S_M2R = 11,
                 S_RW = 12, S_MW = 13, S_LEXT = 14, S_ALU = 15, S_FP = 16, S_DSZ = 17,
                 S_RS1 = 18, S_RS2 = 19, S_DST = 20;

  typedef struct {
    string       tag;
    int          sel;
    logic [31:0] val;
  } exp_t;

  exp_t sb[$];
  int   n_vec  = 0;
  int   n_miss = 0;

  function automatic logic [31:0] obs(input int sel);
    case (sel)
      S_INST: return instruction;
      S_D2:   return delay2_out;
      S_IMM:  return imm32;
      S_BT:   return branch_target;
      S_JT:   return jump_target;
      S_BR:   return 32'(branch);
      S_JMP:  return 32'(jump);
      S_JAL:  return 32'(jal);
      S_JAR:  return 32'(jar);
      S_RDST: return 32'(regdst);
      S_ASRC: return 32'(alusrc);
      S_M2R:  return 32'(mem2reg);
      S_RW:   return 32'(regwrite);
      S_MW:   return 32'(memwrite);
      S_LEXT: return 32'(loadext);
      S_ALU:  return 32'(aluctrl);
      S_FP:   return 32'(fpoint_out);
      S_DSZ:  return 32'(dsize);
      S_RS1:  return 32'(rs1);
      S_RS2:  return 32'(rs2);
      S_DST:  return 32'(destreg);
      default: return 32'hxxxx_xxxx;
    endcase
  endfunction

  task automatic want(input string tag, input int sel, input logic [31:0] val);
    exp_t e;
    e.tag = tag;
    e.sel = sel;
    e.val = val;
    sb.push_back(e);
  endtask

  task automatic drain();
    exp_t        e;
    logic [31:0] o;
    while (sb.size() > 0) begin
      e = sb.pop_front();
      o = obs(e.sel);
      n_vec++;
      assert (o === e.val) else begin
        n_miss++;
        $error("FAIL %s: observed %h expected %h", e.tag, o, e.val);
      end
    end
  endtask

  // Check after the latch edge, or after a settle for input-only changes
  task automatic tick();
    @(posedge clk);
    @(negedge clk);
    drain();
  endtask

  task automatic settle();
    #1;
    drain();
  endtask

  function automatic logic [31:0] mk_i(input logic [5:0] op, input logic [4:0] rs,
                                       input logic [4:0] rt, input logic [15:0] imm);
    return {op, rs, rt, imm};
  endfunction

  function automatic logic [31:0] mk_r(input logic [4:0] rs, input logic [4:0] rt,
                                       input logic [4:0] rd, input logic [5:0] fn);
    return {6'h00, rs, rt, rd, 5'd0, fn};
  endfunction

  initial begin
    rst = 1'b1; stall = 1'b1; inst_in = 32'hFFFF_FFFF; delay_in = 32'hFFFF_FFFF;
    delay2_in = 32'hDEAD_BEEF; rs1_data = '0; prior_alu = '0; wb_data = '0; fwd_sel_a = 2'd0;
    @(negedge clk);

    // Reset has priority over stall
    want("rst_inst", S_INST, 32'h0); want("rst_d2", S_D2, 32'h0);
    want("rst_rw", S_RW, 32'h0); want("rst_mw", S_MW, 32'h0);
    want("rst_br", S_BR, 32'h0); want("rst_jmp", S_JMP, 32'h0);
    want("rst_alu", S_ALU, 32'h0); want("rst_fp", S_FP, 32'h0);
    want("rst_imm", S_IMM, 32'h0); want("rst_bt", S_BT, 32'h0);
    tick();

    rst = 1'b0; stall = 1'b0; inst_in = 32'h1020_0008; delay_in = 32'h100;
    want("beqz_br", S_BR, 32'h1); want("beqz_bt", S_BT, 32'h108);
    want("beqz_rw", S_RW, 32'h0); want("beqz_rs1", S_RS1, 32'd1);
    tick();
    stall = 1'b1; rs1_data = 32'd5;
    want("beqz_nt", S_BR, 32'h0);
    settle();

    stall = 1'b0; inst_in = 32'h1420_FFFC; fwd_sel_a = 2'd1; prior_alu = 32'd7;
    want("bnez_br", S_BR, 32'h1); want("bnez_bt", S_BT, 32'hFC);
    want("bnez_imm", S_IMM, 32'hFFFF_FFFC);
    tick();
    stall = 1'b1; fwd_sel_a = 2'd3;
    want("bnez_sel3", S_BR, 32'h0);
    settle();
    fwd_sel_a = 2'd2; wb_data = 32'h0;
    want("bnez_wb0", S_BR, 32'h0);
    settle();
    wb_data = 32'h8000_0000;
    want("bnez_wb", S_BR, 32'h1);
    settle();

    stall = 1'b0; fwd_sel_a = 2'd0; inst_in = 32'h0022_1820; delay2_in = 32'h1234_5678;
    want("add_inst", S_INST, 32'h0022_1820); want("add_rdst", S_RDST, 32'h1);
    want("add_dst", S_DST, 32'd3); want("add_rw", S_RW, 32'h1);
    want("add_asrc", S_ASRC, 32'h0); want("add_alu", S_ALU, 32'd0);
    want("add_rs1", S_RS1, 32'd1); want("add_rs2", S_RS2, 32'd2);
    want("add_d2", S_D2, 32'h1234_5678);
    tick();

    // Stall holds the latch while fetch presents a new word
    stall = 1'b1; inst_in = 32'h9022_0004; delay2_in = 32'h0;
    want("stall_inst", S_INST, 32'h0022_1820); want("stall_d2", S_D2, 32'h1234_5678);
    want("stall_rw", S_RW, 32'h1);
    tick();

    stall = 1'b0;
    want("lbu_inst", S_INST, 32'h9022_0004); want("lbu_m2r", S_M2R, 32'h1);
    want("lbu_asrc", S_ASRC, 32'h1); want("lbu_dsz", S_DSZ, 32'd0);
    want("lbu_lext", S_LEXT, 32'h0); want("lbu_dst", S_DST, 32'd2);
    want("lbu_imm", S_IMM, 32'd4); want("lbu_rw", S_RW, 32'h1);
    tick();

    inst_in = mk_i(6'h21, 5'd1, 5'd4, 16'h8000);
    want("lh_lext", S_LEXT, 32'h1); want("lh_dsz", S_DSZ, 32'd1);
    want("lh_imm", S_IMM, 32'hFFFF_8000);
    tick();

    inst_in = mk_i(6'h2B, 5'd2, 5'd3, 16'hFFF8);
    want("sw_mw", S_MW, 32'h1); want("sw_rw", S_RW, 32'h0); want("sw_asrc", S_ASRC, 32'h1);
    want("sw_dsz", S_DSZ, 32'd2); want("sw_imm", S_IMM, 32'hFFFF_FFF8);
    want("sw_m2r", S_M2R, 32'h0);
    tick();

    inst_in = {6'h03, 26'h3FF_FFF0}; delay_in = 32'h2000;
    want("jal_jmp", S_JMP, 32'h1); want("jal_jal", S_JAL, 32'h1); want("jal_jar", S_JAR, 32'h0);
    want("jal_rdst", S_RDST, 32'h1); want("jal_dst", S_DST, 32'd31);
    want("jal_jt", S_JT, 32'h1FF0); want("jal_br", S_BR, 32'h0);
    tick();

    inst_in = mk_i(6'h12, 5'd5, 5'd0, 16'h0);
    want("jr_jmp", S_JMP, 32'h1); want("jr_jar", S_JAR, 32'h1); want("jr_jal", S_JAL, 32'h0);
    want("jr_rw", S_RW, 32'h0); want("jr_rs1", S_RS1, 32'd5);
    tick();

    inst_in = mk_i(6'h0F, 5'd0, 5'd1, 16'h8000);
    want("lhi_imm", S_IMM, 32'h0000_8000); want("lhi_alu", S_ALU, 32'd14);
    want("lhi_asrc", S_ASRC, 32'h1); want("lhi_rw", S_RW, 32'h1); want("lhi_dst", S_DST, 32'd1);
    tick();

    inst_in = mk_i(6'h08, 5'd3, 5'd4, 16'h8000);
    want("addi_imm", S_IMM, 32'hFFFF_8000); want("addi_alu", S_ALU, 32'd0);
    want("addi_dst", S_DST, 32'd4);
    tick();

    inst_in = mk_i(6'h1A, 5'd1, 5'd2, 16'hFFFF);
    want("slti_alu", S_ALU, 32'd10); want("slti_imm", S_IMM, 32'hFFFF_FFFF);
    tick();

    inst_in = mk_i(6'h0C, 5'd1, 5'd2, 16'hFFFF);
    want("andi_alu", S_ALU, 32'd2); want("andi_imm", S_IMM, 32'h0000_FFFF);
    tick();

    inst_in = mk_r(5'd1, 5'd2, 5'd7, 6'h07);
    want("sra_alu", S_ALU, 32'd7); want("sra_dst", S_DST, 32'd7);
    tick();

    inst_in = mk_r(5'd1, 5'd2, 5'd7, 6'h2D);
    want("sge_alu", S_ALU, 32'd13);
    tick();

    inst_in = mk_r(5'd1, 5'd2, 5'd7, 6'h3F);
    want("badfn_rw", S_RW, 32'h0); want("badfn_rdst", S_RDST, 32'h0);
    want("badfn_dst", S_DST, 32'd2);
    tick();

    inst_in = mk_i(6'h3F, 5'd31, 5'd31, 16'hFFFF);
    want("badop_rw", S_RW, 32'h0); want("badop_mw", S_MW, 32'h0);
    want("badop_jmp", S_JMP, 32'h0); want("badop_asrc", S_ASRC, 32'h0);
    tick();

    inst_in = mk_i(6'h15, 5'd1, 5'd2, 16'h0);
    want("nop_rw", S_RW, 32'h0);
    tick();

    inst_in = {6'h01, 5'd1, 5'd2, 5'd3, 5'd0, 6'h01};
`ifdef FPU_DECODE_EN
    want("fpr_rw", S_RW, 32'h1); want("fpr_fp", S_FP, 32'd2);
`else
    want("fpr_rw", S_RW, 32'h0); want("fpr_fp", S_FP, 32'd0);
`endif
    tick();

    inst_in = mk_i(6'h27, 5'd1, 5'd2, 16'h0008);
`ifdef FPU_DECODE_EN
    want("ld_m2r", S_M2R, 32'h1); want("ld_dsz", S_DSZ, 32'd3); want("ld_fp", S_FP, 32'd2);
`else
    want("ld_m2r", S_M2R, 32'h0); want("ld_dsz", S_DSZ, 32'd0); want("ld_fp", S_FP, 32'd0);
`endif
    tick();

    inst_in = mk_i(6'h06, 5'd1, 5'd0, 16'h0004); rs1_data = 32'd5;
`ifdef FPU_DECODE_EN
    want("bfpt_br", S_BR, 32'h1);
`else
    want("bfpt_br", S_BR, 32'h0);
`endif
    tick();

    rst = 1'b1; inst_in = 32'h0022_1820;
    want("rst2_inst", S_INST, 32'h0); want("rst2_rw", S_RW, 32'h0);
    tick();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
